// File: rtl/data_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : data_tile_scheduler
// Description : Data-side sequencer for the Winograd conv engine. It latches
//               the block grid and input-depth index, preloads the input-
//               buffer window for that depth slice, reports ready, and then
//               walks the tile grid row-major, handing one tile coordinate
//               per valid/ready transfer to the PE array.
// Revision    : 1.0 - initial release
// ============================================================================
module data_tile_scheduler #(
    parameter int ADDR_W        = 10,
    parameter int ID_STRIDE     = 64,
    parameter int PRELOAD_READS = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_prepare_i,
    input  logic              data_start_i,
    input  logic [7:0]        block_width_i,
    input  logic [7:0]        block_height_i,
    input  logic [3:0]        data_id_i,
    output logic              data_ready_o,
    output logic              data_complete_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              tile_valid_o,
    input  logic              tile_ready_i,
    output logic [7:0]        tile_row_o,
    output logic [7:0]        tile_col_o,
    output logic              tile_last_o
);

    // Preload counter only needs to reach PRELOAD_READS-1.
    localparam int c_K_W    = (PRELOAD_READS > 1) ? $clog2(PRELOAD_READS) : 1;
    // Base address product is formed 4 bits wider than the address, then truncated.
    localparam int c_BASE_W = ADDR_W + 4;

    localparam logic [c_K_W-1:0] c_K_LAST = c_K_W'(PRELOAD_READS - 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_PRELOAD = 3'd1;
    localparam logic [2:0] c_READY   = 3'd2;
    localparam logic [2:0] c_RUN     = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    logic [2:0]          r_state;
    logic [7:0]          r_width;
    logic [7:0]          r_height;
    logic [3:0]          r_id;
    logic [c_K_W-1:0]    r_k;
    logic [7:0]          r_row;
    logic [7:0]          r_col;

    logic [c_BASE_W-1:0] w_base;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_col_end;
    logic                w_last;

    // Slice base address and current preload read address (wraps at 2^ADDR_W).
    always_comb begin
        w_base    = c_BASE_W'(r_id) * c_BASE_W'(ID_STRIDE);
        w_addr    = w_base[ADDR_W-1:0] + ADDR_W'(r_k);
        w_col_end = (r_col == r_width - 8'd1);
        w_last    = w_col_end && (r_row == r_height - 8'd1);
    end

    // Sequencer: latch job parameters, count preload reads, walk the tile grid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_width  <= 8'd0;
            r_height <= 8'd0;
            r_id     <= 4'd0;
            r_k      <= '0;
            r_row    <= 8'd0;
            r_col    <= 8'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (data_prepare_i) begin
                        // A zero dimension still describes a single tile.
                        r_width  <= (block_width_i  == 8'd0) ? 8'd1 : block_width_i;
                        r_height <= (block_height_i == 8'd0) ? 8'd1 : block_height_i;
                        r_id     <= data_id_i;
                        r_k      <= '0;
                        r_state  <= c_PRELOAD;
                    end
                end
                c_PRELOAD: begin
                    if (r_k == c_K_LAST) begin
                        r_state <= c_READY;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                c_READY: begin
                    if (data_start_i) begin
                        r_row   <= 8'd0;
                        r_col   <= 8'd0;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    if (tile_ready_i) begin
                        if (w_last) begin
                            // Park the counters at zero so they never step past the grid.
                            r_row   <= 8'd0;
                            r_col   <= 8'd0;
                            r_state <= c_DONE;
                        end else if (w_col_end) begin
                            r_col <= 8'd0;
                            r_row <= r_row + 8'd1;
                        end else begin
                            r_col <= r_col + 8'd1;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state; everything is zero outside its owning state.
    always_comb begin
        data_ready_o    = (r_state == c_READY);
        data_complete_o = (r_state == c_DONE);
        rd_en_o         = (r_state == c_PRELOAD);
        rd_addr_o       = rd_en_o ? w_addr : '0;
        tile_valid_o    = (r_state == c_RUN);
        tile_row_o      = tile_valid_o ? r_row : 8'd0;
        tile_col_o      = tile_valid_o ? r_col : 8'd0;
        tile_last_o     = tile_valid_o && w_last;
    end

endmodule
`default_nettype wire

// File: tb/tb_data_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_tile_scheduler
// Description : Scoreboard bench for data_tile_scheduler. Stimulus tasks push
//               expected read addresses and tile coordinates into queues; a
//               negedge monitor pops and compares whenever the DUT presents
//               a read strobe or a tile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_tile_scheduler;

    localparam int c_ADDR_W  = 10;
    localparam int c_STRIDE  = 64;
    localparam int c_STRIDE2 = 68;
    localparam int c_READS   = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       data_prepare_i;
    logic       data_start_i;
    logic       tile_ready_i;
    logic [7:0] block_width_i;
    logic [7:0] block_height_i;
    logic [3:0] data_id_i;
    logic       data_ready_o;
    logic       data_complete_o;
    logic       rd_en_o;
    logic [9:0] rd_addr_o;
    logic       tile_valid_o;
    logic [7:0] tile_row_o;
    logic [7:0] tile_col_o;
    logic       tile_last_o;

    // Second instance with a stride that makes the preload window wrap.
    logic       prep2;
    logic       ready2;
    logic       complete2;
    logic       rd_en2;
    logic [9:0] rd_addr2;
    logic       valid2;
    logic [7:0] row2;
    logic [7:0] col2;
    logic       last2;

    int         checks = 0;
    int         errors = 0;
    int         valid_cycles = 0;
    logic       pend_done = 1'b0;

    logic [9:0]  addr_q[$];
    logic [9:0]  addr2_q[$];
    logic [16:0] tile_q[$];   // {last, row, col}

    always #5 clk = ~clk;

    data_tile_scheduler #(
        .ADDR_W(c_ADDR_W), .ID_STRIDE(c_STRIDE), .PRELOAD_READS(c_READS)
    ) dut (
        .clk(clk), .reset(reset),
        .data_prepare_i(data_prepare_i), .data_start_i(data_start_i),
        .block_width_i(block_width_i), .block_height_i(block_height_i),
        .data_id_i(data_id_i),
        .data_ready_o(data_ready_o), .data_complete_o(data_complete_o),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
        .tile_valid_o(tile_valid_o), .tile_ready_i(tile_ready_i),
        .tile_row_o(tile_row_o), .tile_col_o(tile_col_o), .tile_last_o(tile_last_o)
    );

    data_tile_scheduler #(
        .ADDR_W(c_ADDR_W), .ID_STRIDE(c_STRIDE2), .PRELOAD_READS(c_READS)
    ) dut_wrap (
        .clk(clk), .reset(reset),
        .data_prepare_i(prep2), .data_start_i(1'b0),
        .block_width_i(block_width_i), .block_height_i(block_height_i),
        .data_id_i(data_id_i),
        .data_ready_o(ready2), .data_complete_o(complete2),
        .rd_en_o(rd_en2), .rd_addr_o(rd_addr2),
        .tile_valid_o(valid2), .tile_ready_i(1'b0),
        .tile_row_o(row2), .tile_col_o(col2), .tile_last_o(last2)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare reads, tiles (including held tiles while stalled) and completion.
    always @(negedge clk) begin
        logic [16:0] exp_tile;
        if (!reset) begin
            if (rd_en_o) begin
                if (addr_q.size() == 0) check("unexpected_read", int'(rd_en_o), 0);
                else check("rd_addr", int'(rd_addr_o), int'(addr_q.pop_front()));
            end
            if (rd_en2) begin
                if (addr2_q.size() == 0) check("unexpected_read_wrap", int'(rd_en2), 0);
                else check("rd_addr_wrap", int'(rd_addr2), int'(addr2_q.pop_front()));
            end
            if (pend_done || data_complete_o)
                check("data_complete", int'(data_complete_o), int'(pend_done));
            pend_done = 1'b0;
            if (tile_valid_o) begin
                valid_cycles++;
                if (tile_q.size() == 0) begin
                    check("unexpected_tile", int'(tile_valid_o), 0);
                end else begin
                    exp_tile = tile_q[0];
                    check(tile_ready_i ? "tile_row"  : "stall_row",  int'(tile_row_o),  int'(exp_tile[15:8]));
                    check(tile_ready_i ? "tile_col"  : "stall_col",  int'(tile_col_o),  int'(exp_tile[7:0]));
                    check(tile_ready_i ? "tile_last" : "stall_last", int'(tile_last_o), int'(exp_tile[16]));
                    if (tile_ready_i) begin
                        void'(tile_q.pop_front());
                        pend_done = exp_tile[16];
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"},    int'(data_ready_o),    0);
        check({tag, "_complete"}, int'(data_complete_o), 0);
        check({tag, "_rd_en"},    int'(rd_en_o),         0);
        check({tag, "_rd_addr"},  int'(rd_addr_o),       0);
        check({tag, "_valid"},    int'(tile_valid_o),    0);
        check({tag, "_row"},      int'(tile_row_o),      0);
        check({tag, "_col"},      int'(tile_col_o),      0);
        check({tag, "_last"},     int'(tile_last_o),     0);
    endtask

    // Issue a prepare; optionally hold start high during the preload (must be ignored).
    task automatic do_prepare(input int w, input int h, input int id, input bit abuse);
        int cnt;
        block_width_i  = w[7:0];
        block_height_i = h[7:0];
        data_id_i      = id[3:0];
        for (int k = 0; k < c_READS; k++)
            addr_q.push_back(10'((id * c_STRIDE + k) % 1024));
        data_prepare_i = 1'b1;
        if (abuse) data_start_i = 1'b1;
        cnt = 0;
        while (cnt < 40) begin
            tick();
            cnt++;
            data_prepare_i = 1'b0;
            if (cnt >= 4) data_start_i = 1'b0;
            if (data_ready_o) break;
        end
        data_start_i = 1'b0;
        check("ready_latency", cnt, c_READS + 1);
        check("preload_reads_left", addr_q.size(), 0);
    endtask

    // Start the walk and push the row-major tile sequence for the latched grid.
    task automatic do_walk(input int w, input int h, input bit random_ready, input bit abuse);
        int we;
        int he;
        int cyc;
        we = (w == 0) ? 1 : w;
        he = (h == 0) ? 1 : h;
        for (int r = 0; r < he; r++)
            for (int c = 0; c < we; c++)
                tile_q.push_back({(r == he - 1 && c == we - 1), r[7:0], c[7:0]});
        valid_cycles = 0;
        tile_ready_i = 1'b0;
        data_start_i = 1'b1;
        tick();
        data_start_i = 1'b0;
        if (abuse) begin
            data_prepare_i = 1'b1;
            block_width_i  = 8'd7;
            block_height_i = 8'd9;
            data_id_i      = 4'd9;
        end
        cyc = 0;
        while ((tile_q.size() != 0 || pend_done) && cyc < 3000) begin
            tile_ready_i = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cyc == 3) data_prepare_i = 1'b0;
            tick();
            cyc++;
        end
        tile_ready_i   = 1'b0;
        data_prepare_i = 1'b0;
        check("walk_tiles_left", tile_q.size(), 0);
        if (!random_ready) check("back_to_back_cycles", valid_cycles, we * he);
        tick();
        tick();
        check("idle_after_done_valid", int'(tile_valid_o), 0);
        check("idle_after_done_ready", int'(data_ready_o), 0);
    endtask

    initial begin
        reset          = 1'b1;
        data_prepare_i = 1'b0;
        data_start_i   = 1'b0;
        tile_ready_i   = 1'b0;
        block_width_i  = 8'd0;
        block_height_i = 8'd0;
        data_id_i      = 4'd0;
        prep2          = 1'b0;
        repeat (3) tick();
        check_quiet("reset");
        reset = 1'b0;
        tick();

        // Preload of depth slice 3 (192..197), then a 3x2 walk at full rate.
        do_prepare(3, 2, 3, 1'b0);
        do_walk(3, 2, 1'b0, 1'b0);

        // 2x2 walk under random backpressure.
        do_prepare(2, 2, 1, 1'b0);
        do_walk(2, 2, 1'b1, 1'b0);

        // Zero dimensions collapse to one tile.
        do_prepare(0, 0, 0, 1'b0);
        do_walk(0, 0, 1'b0, 1'b0);

        // Widest single row; id 15 gives 960..965.
        do_prepare(255, 1, 15, 1'b0);
        do_walk(255, 1, 1'b0, 1'b0);

        // Stride 68, id 15: 1020..1023 then 0, 1.
        data_id_i = 4'd15;
        for (int k = 0; k < c_READS; k++)
            addr2_q.push_back(10'((15 * c_STRIDE2 + k) % 1024));
        prep2 = 1'b1;
        tick();
        prep2 = 1'b0;
        repeat (8) tick();
        check("wrap_reads_left", addr2_q.size(), 0);
        check("wrap_ready", int'(ready2), 1);

        // Start during preload, prepare and new dims during the walk: all ignored.
        do_prepare(3, 3, 5, 1'b1);
        do_walk(3, 3, 1'b0, 1'b1);

        // Reset in the middle of a walk: abort with no completion pulse.
        do_prepare(2, 3, 2, 1'b0);
        tile_q.push_back({1'b0, 8'd0, 8'd0});
        tile_q.push_back({1'b0, 8'd0, 8'd1});
        data_start_i = 1'b1;
        tick();
        data_start_i = 1'b0;
        tile_ready_i = 1'b1;
        tick();
        tick();
        reset        = 1'b1;
        tile_ready_i = 1'b0;
        check("pre_reset_tiles_left", tile_q.size(), 0);
        tile_q.delete();
        pend_done = 1'b0;
        repeat (3) tick();
        check_quiet("midrun_reset");
        reset = 1'b0;
        repeat (4) tick();
        check_quiet("post_reset");

        // Back in IDLE: a fresh single-tile job runs normally.
        do_prepare(1, 1, 0, 1'b0);
        do_walk(1, 1, 1'b0, 1'b0);

        check("leftover_addr", addr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
